sram_mem_controller: RTL and testbench

Multi-cycle controller between the MEM stage and a 16-bit asynchronous SRAM. It turns each 32-bit load or store into two 16-bit SRAM accesses, low half first, with a programmable number of wait cycles per half. While an access is in progress it drives `ready` low; the top level uses that signal to freeze every pipeline stage. It replaces the single-cycle data memory on the MEM path.

---
 rtl/sram_mem_controller.sv | 154 +++++++++++++++
 tb/tb_sram_mem_controller.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sram_mem_controller.sv
// Two-half (16-bit) access sequencer between the MEM stage and an asynchronous SRAM.
// Each 32-bit load/store becomes a low-half then a high-half bus cycle; ready=0 freezes the pipeline.
module sram_mem_controller #(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    input  logic [15:0] sram_dq_in,
    output logic        sram_dq_oe,
    output logic        sram_we_n,
    output logic        sram_oe_n
);

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        op_write, op_write_nxt;
    logic [16:0] word_addr, word_addr_nxt;
    logic [31:0] wdata, wdata_nxt;
    logic [31:0] read_data_nxt;
    logic [17:0] sram_addr_nxt;
    logic [15:0] sram_dq_out_nxt;
    logic        sram_dq_oe_nxt, sram_we_n_nxt, sram_oe_n_nxt;

    logic        req;
    logic [31:0] offset;
    logic        unused_offset_bits;

    assign req    = rd_en | wr_en;
    assign offset = address - BASE_ADDR;
    // Bits above the SRAM range wrap away and the byte lane bits are ignored.
    assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

    assign ready = ((state == IDLE) && !req) || (state == DONE);

    // NOTE: every variable gets its hold value first so no path through the case leaves one unassigned (no latches).
    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        op_write_nxt    = op_write;
        word_addr_nxt   = word_addr;
        wdata_nxt       = wdata;
        read_data_nxt   = read_data;
        sram_addr_nxt   = sram_addr;
        sram_dq_out_nxt = sram_dq_out;
        sram_dq_oe_nxt  = sram_dq_oe;
        sram_we_n_nxt   = sram_we_n;
        sram_oe_n_nxt   = sram_oe_n;

        unique case (state)
            IDLE: begin
                if (req) begin
                    op_write_nxt   = wr_en;
                    word_addr_nxt  = offset[18:2];
                    wdata_nxt      = write_data;
                    cnt_nxt        = 4'd0;
                    state_nxt      = LOW;
                    sram_addr_nxt  = {offset[18:2], 1'b0};
                    sram_dq_oe_nxt = wr_en;
                    sram_we_n_nxt  = ~wr_en;
                    sram_oe_n_nxt  = wr_en;
                    if (wr_en) begin
                        sram_dq_out_nxt = write_data[15:0];
                    end
                end
            end

            LOW: begin
                cnt_nxt = cnt + 4'd1;
                if (cnt == LAST_CNT) begin
                    if (!op_write) begin
                        read_data_nxt[15:0] = sram_dq_in;
                    end
                    cnt_nxt       = 4'd0;
                    state_nxt     = HIGH;
                    sram_addr_nxt = {word_addr, 1'b1};
                    if (op_write) begin
                        sram_dq_out_nxt = wdata[31:16];
                    end
                end
            end

            HIGH: begin
                cnt_nxt = cnt + 4'd1;
                if (cnt == LAST_CNT) begin
                    if (!op_write) begin
                        read_data_nxt[31:16] = sram_dq_in;
                    end
                    cnt_nxt        = 4'd0;
                    state_nxt      = DONE;
                    // Strobes drop on DONE entry; the address stays where it was.
                    sram_dq_oe_nxt = 1'b0;
                    sram_we_n_nxt  = 1'b1;
                    sram_oe_n_nxt  = 1'b1;
                end
            end

            DONE: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            op_write    <= 1'b0;
            word_addr   <= '0;
            wdata       <= '0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            op_write    <= op_write_nxt;
            word_addr   <= word_addr_nxt;
            wdata       <= wdata_nxt;
            read_data   <= read_data_nxt;
            sram_addr   <= sram_addr_nxt;
            sram_dq_out <= sram_dq_out_nxt;
            sram_dq_oe  <= sram_dq_oe_nxt;
            sram_we_n   <= sram_we_n_nxt;
            sram_oe_n   <= sram_oe_n_nxt;
        end
    end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Scoreboard bench: stimulus queues expected transactions, a negedge monitor checks each completed access
// against a behavioural SRAM. Instance a runs WAIT_CYCLES=2, instance b runs WAIT_CYCLES=1.
module tb_sram_mem_controller;

    typedef struct {
        int          busy;
        logic        wr;
        logic [17:0] a0;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        a_rd, a_wr, b_rd, b_wr;
    logic [31:0] address, write_data;

    logic [31:0] a_read_data, b_read_data;
    logic        a_ready, b_ready;
    logic [17:0] a_sram_addr, b_sram_addr;
    logic [15:0] a_dq_out, b_dq_out, a_dq_in, b_dq_in;
    logic        a_dq_oe, b_dq_oe, a_we_n, b_we_n, a_oe_n, b_oe_n;

    logic [15:0] mem [0:262143];

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    sram_mem_controller #(.WAIT_CYCLES(2), .BASE_ADDR(32'd1024)) dut_a (
        .clk(clk), .rst(rst), .rd_en(a_rd), .wr_en(a_wr),
        .address(address), .write_data(write_data), .read_data(a_read_data), .ready(a_ready),
        .sram_addr(a_sram_addr), .sram_dq_out(a_dq_out), .sram_dq_in(a_dq_in),
        .sram_dq_oe(a_dq_oe), .sram_we_n(a_we_n), .sram_oe_n(a_oe_n)
    );

    sram_mem_controller #(.WAIT_CYCLES(1), .BASE_ADDR(32'd1024)) dut_b (
        .clk(clk), .rst(rst), .rd_en(b_rd), .wr_en(b_wr),
        .address(address), .write_data(write_data), .read_data(b_read_data), .ready(b_ready),
        .sram_addr(b_sram_addr), .sram_dq_out(b_dq_out), .sram_dq_in(b_dq_in),
        .sram_dq_oe(b_dq_oe), .sram_we_n(b_we_n), .sram_oe_n(b_oe_n)
    );

    assign a_dq_in = mem[a_sram_addr];
    assign b_dq_in = mem[b_sram_addr];

    always @(negedge clk) begin
        if (!a_we_n && a_dq_oe) mem[a_sram_addr] <= a_dq_out;
        if (!b_we_n && b_dq_oe) mem[b_sram_addr] <= b_dq_out;
    end

    // Monitor view of whichever instance is under test.
    logic        m_ready, m_we_n, m_oe_n, m_dq_oe;
    logic [17:0] m_addr;
    logic [15:0] m_dq_out;
    logic [31:0] m_rdata;
    int          m_w;

    assign m_ready  = sel ? b_ready     : a_ready;
    assign m_we_n   = sel ? b_we_n      : a_we_n;
    assign m_oe_n   = sel ? b_oe_n      : a_oe_n;
    assign m_dq_oe  = sel ? b_dq_oe     : a_dq_oe;
    assign m_addr   = sel ? b_sram_addr : a_sram_addr;
    assign m_dq_out = sel ? b_dq_out    : a_dq_out;
    assign m_rdata  = sel ? b_read_data : a_read_data;
    assign m_w      = sel ? 1 : 2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    exp_t exp_q[$];
    exp_t mon_e;
    int   busy = 0, n_lo = 0, n_hi = 0, n_bad = 0, done_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            busy = 0; n_lo = 0; n_hi = 0; n_bad = 0;
        end else begin
            if (!m_ready) busy++;
            if (exp_q.size() > 0 && (!m_we_n || !m_oe_n)) begin
                mon_e = exp_q[0];
                if (m_addr == mon_e.a0 && (mon_e.wr ?
                        (!m_we_n && m_oe_n && m_dq_oe && m_dq_out == mon_e.d0) :
                        (m_we_n && !m_oe_n && !m_dq_oe)))
                    n_lo++;
                else if (m_addr == {mon_e.a0[17:1], 1'b1} && (mon_e.wr ?
                        (!m_we_n && m_oe_n && m_dq_oe && m_dq_out == mon_e.d1) :
                        (m_we_n && !m_oe_n && !m_dq_oe)))
                    n_hi++;
                else
                    n_bad++;
            end
            if (m_ready && busy > 0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_completion", 32'(busy), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("busy_cycles", 32'(busy), 32'(mon_e.busy));
                    check("low_half_cycles", 32'(n_lo), 32'(m_w));
                    check("high_half_cycles", 32'(n_hi), 32'(m_w));
                    check("bad_bus_cycles", 32'(n_bad), 32'd0);
                    check("read_data", m_rdata, mon_e.rdata);
                    check("done_strobes", {29'd0, m_we_n, m_oe_n, m_dq_oe}, 32'b110);
                end
                busy = 0; n_lo = 0; n_hi = 0; n_bad = 0;
                done_cnt++;
            end
        end
    end

    // Called just after a rising edge with the controller idle; returns just after the edge that ends DONE.
    task automatic do_access(input logic s, input logic wr, input logic rd,
                             input logic [31:0] addr, input logic [31:0] wd, input int exp_busy,
                             input logic [17:0] a0, input logic [15:0] d0, input logic [15:0] d1,
                             input logic [31:0] rdata);
        exp_t e;
        int   start;
        int   n;
        e.busy = exp_busy; e.wr = wr; e.a0 = a0; e.d0 = d0; e.d1 = d1; e.rdata = rdata;
        exp_q.push_back(e);
        sel = s; address = addr; write_data = wd;
        if (s) begin b_wr = wr; b_rd = rd; end
        else   begin a_wr = wr; a_rd = rd; end
        #1;
        check("ready_drops_on_req", {31'd0, m_ready}, 32'd0);
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < 60) begin
            @(posedge clk);
            n++;
        end
        check("access_completed", 32'(done_cnt - start), 32'd1);
        #1;
        a_wr = 1'b0; a_rd = 1'b0; b_wr = 1'b0; b_rd = 1'b0;
    endtask

    initial begin
        mem[2]        = 16'h5678;
        mem[3]        = 16'h1234;
        mem[18'h3FFFE] = 16'hCAFE;
        mem[18'h3FFFF] = 16'hBABE;
        sel = 1'b0; a_rd = 1'b0; a_wr = 1'b0; b_rd = 1'b0; b_wr = 1'b0;
        address = '0; write_data = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_ready", {31'd0, a_ready}, 32'd1);
        check("reset_strobes", {29'd0, a_we_n, a_oe_n, a_dq_oe}, 32'b110);
        check("reset_read_data", a_read_data, 32'd0);
        check("reset_sram_addr", {14'd0, a_sram_addr}, 32'd0);
        check("reset_dq_out", {16'd0, a_dq_out}, 32'd0);

        // Store 0xDEADBEEF at word 0, then load the preloaded word at 1028.
        do_access(1'b0, 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 5, 18'd0, 16'hBEEF, 16'hDEAD, 32'h0);
        check("sram_half0_after_store", {16'd0, mem[0]}, 32'h0000BEEF);
        check("sram_half1_after_store", {16'd0, mem[1]}, 32'h0000DEAD);
        do_access(1'b0, 1'b0, 1'b1, 32'd1028, 32'h0, 5, 18'd2, 16'h0, 16'h0, 32'h12345678);

        // Store then load from 1040 issued straight after DONE.
        do_access(1'b0, 1'b1, 1'b0, 32'd1040, 32'h0BADF00D, 5, 18'd8, 16'hF00D, 16'h0BAD, 32'h12345678);
        do_access(1'b0, 1'b0, 1'b1, 32'd1040, 32'h0, 5, 18'd8, 16'h0, 16'h0, 32'h0BADF00D);

        // Both enables: a write, read_data unchanged.
        do_access(1'b0, 1'b1, 1'b1, 32'd1024, 32'hA5A55A5A, 5, 18'd0, 16'h5A5A, 16'hA5A5, 32'h0BADF00D);
        check("both_en_half0", {16'd0, mem[0]}, 32'h00005A5A);
        check("both_en_half1", {16'd0, mem[1]}, 32'h0000A5A5);

        // Reset in the first HIGH cycle of a store to 1048.
        sel = 1'b0; address = 32'd1048; write_data = 32'h11112222; a_wr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("high_half_addr_before_reset", {14'd0, a_sram_addr}, 32'd13);
        rst = 1'b1; a_wr = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        check("post_reset_strobes", {29'd0, a_we_n, a_oe_n, a_dq_oe}, 32'b110);
        check("post_reset_read_data", a_read_data, 32'd0);
        check("post_reset_ready", {31'd0, a_ready}, 32'd1);
        do_access(1'b0, 1'b0, 1'b1, 32'd1028, 32'h0, 5, 18'd2, 16'h0, 16'h0, 32'h12345678);

        // WAIT_CYCLES=1 load wrapping below BASE_ADDR.
        do_access(1'b1, 1'b0, 1'b1, 32'd1020, 32'h0, 3, 18'h3FFFE, 16'h0, 16'h0, 32'hBABECAFE);

        repeat (2) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
